pipeline_ctrl: RTL

Central pipeline sequencer for the six-stage core (IF, ID, EXE, MEM, MEM2, WB). It merges the ID data-hazard stalls, I/D-cache busy, multi-cycle divider, branch-mispredict and exception-flush requests into one consistent set of per-stage write-enable and flush controls. It also sequences the divider handshake and counts frontend-stall cycles. It sits beside the stage registers and drives every `*_Wr` and `*_Flush` input.

---
 rtl/pipeline_ctrl_pkg.sv | 35 +++
 rtl/pipeline_ctrl_stall_counter.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// CPU_Defines : shared sequencer state and per-stage control bundle types
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package CPU_Defines;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DROP     = 2'd2
  } PipeCtrlState;

  typedef struct packed {
    logic pc_wr;
    logic id_wr;
    logic exe_wr;
    logic mem_wr;
    logic mem2_wr;
    logic wb_wr;
    logic if_flush;
    logic id_flush;
    logic exe_flush;
    logic mem_flush;
    logic mem2_flush;
  } StageCtrl;

  // Free-running pipeline: every stage advances, nothing squashed.
  localparam StageCtrl CTRL_ADVANCE = StageCtrl'(11'b111111_00000);
  localparam StageCtrl CTRL_FREEZE  = StageCtrl'(11'b000000_00000);

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_stall_counter.sv
// ============================================================================
// stall_counter : saturating event counter with async active-low clear
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl : six-stage pipeline sequencer (stalls, flushes, divider)
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import CPU_Defines::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ID_EX_DH_Stall,
  input  logic             ID_MEM1_DH_Stall,
  input  logic             ID_MEM2_DH_Stall,
  input  logic             Icache_Busy,
  input  logic             Dcache_Busy,
  input  logic             EXE_IsDiv,
  input  logic             Div_Done,
  input  logic             EXE_BranchFail,
  input  logic             MEM_Except,
  output logic             PC_Wr,
  output logic             ID_Wr,
  output logic             EXE_Wr,
  output logic             MEM_Wr,
  output logic             MEM2_Wr,
  output logic             WB_Wr,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             EXE_Flush,
  output logic             MEM_Flush,
  output logic             MEM2_Flush,
  output logic             Div_Start,
  output logic             Div_Abort,
  output logic [CNT_W-1:0] Stall_Cnt
);

  PipeCtrlState state_q;
  PipeCtrlState state_d;
  StageCtrl     ctrl;
  logic         dh_stall;

  assign dh_stall = ID_EX_DH_Stall | ID_MEM1_DH_Stall | ID_MEM2_DH_Stall;

  always_comb begin
    ctrl      = CTRL_ADVANCE;
    Div_Start = 1'b0;
    Div_Abort = 1'b0;
    state_d   = state_q;

    if (!resetn || Dcache_Busy) begin
      ctrl = CTRL_FREEZE;
    end else if (MEM_Except) begin
      // IF_Flush also covers a simultaneous mispredict; PC loads the vector.
      ctrl.if_flush  = 1'b1;
      ctrl.id_flush  = 1'b1;
      ctrl.exe_flush = 1'b1;
      ctrl.mem_flush = 1'b1;
      Div_Abort      = (state_q == DIV_WAIT);
      state_d        = Icache_Busy ? DROP : RUN;
    end else begin
      case (state_q)
        DIV_WAIT: begin
          if (!Div_Done) begin
            ctrl.pc_wr     = 1'b0;
            ctrl.id_wr     = 1'b0;
            ctrl.exe_wr    = 1'b0;
            ctrl.mem_flush = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        DROP: begin
          // The in-flight fetch is wrong-path, including the one returning now.
          ctrl.id_flush = 1'b1;
          ctrl.pc_wr    = ~Icache_Busy;
          if (!Icache_Busy) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (EXE_IsDiv) begin
            Div_Start      = 1'b1;
            ctrl.pc_wr     = 1'b0;
            ctrl.id_wr     = 1'b0;
            ctrl.exe_wr    = 1'b0;
            ctrl.mem_flush = 1'b1;
            state_d        = DIV_WAIT;
          end else if (EXE_BranchFail) begin
            ctrl.if_flush = 1'b1;
            if (Icache_Busy) begin
              state_d = DROP;
            end
          end else if (dh_stall) begin
            ctrl.pc_wr     = 1'b0;
            ctrl.id_wr     = 1'b0;
            ctrl.exe_flush = 1'b1;
          end else if (Icache_Busy) begin
            ctrl.pc_wr    = 1'b0;
            ctrl.id_flush = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign PC_Wr      = ctrl.pc_wr;
  assign ID_Wr      = ctrl.id_wr;
  assign EXE_Wr     = ctrl.exe_wr;
  assign MEM_Wr     = ctrl.mem_wr;
  assign MEM2_Wr    = ctrl.mem2_wr;
  assign WB_Wr      = ctrl.wb_wr;
  assign IF_Flush   = ctrl.if_flush;
  assign ID_Flush   = ctrl.id_flush;
  assign EXE_Flush  = ctrl.exe_flush;
  assign MEM_Flush  = ctrl.mem_flush;
  assign MEM2_Flush = ctrl.mem2_flush;

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst_n (resetn),
    .inc   (~ctrl.pc_wr),
    .cnt   (Stall_Cnt)
  );

endmodule

`default_nettype wire
